// File: rtl/jk_ctrl_pkg.sv
// Shared op codes and FSM state encoding for the JK bank controller.
package jk_ctrl_pkg;

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_COUNT  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/jk_cell.sv
// Single posedge JK flip-flop, async active-high reset to Q=0 / Qbar=1.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  logic q_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b01:   q_r <= 1'b0;
        2'b10:   q_r <= 1'b1;
        2'b11:   q_r <= ~q_r;
        default: q_r <= q_r;
      endcase
    end
  end

  assign q    = q_r;
  assign qbar = ~q_r;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer driving per-bit J/K of a WIDTH-cell JK bank.
// Optional abort support is enabled with JK_BANK_CTRL_ABORT_EN.
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [CNT_W-1:0] cmd_len,
`ifdef JK_BANK_CTRL_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state;
  logic [CNT_W-1:0] remaining;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] arg_r;
  logic [CNT_W-1:0] len_sel;
  logic             stop_now;
  logic             step_en;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_bus;
  logic [WIDTH-1:0] qbar_bus;

  // CLEAR and LOAD always take exactly one step regardless of cmd_len.
  assign len_sel = (cmd_op == OP_CLEAR || cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_len;

`ifdef JK_BANK_CTRL_ABORT_EN
  assign stop_now = (state == ST_EXEC) && abort;
`else
  assign stop_now = 1'b0;
`endif

  assign step_en = (state == ST_EXEC) && !stop_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            remaining <= len_sel;
            state     <= (len_sel == '0) ? ST_DONE : ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (stop_now) begin
            remaining <= '0;
            state     <= ST_DONE;
          end else begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Command payload is datapath: latched on accept, no reset needed.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && cmd_valid) begin
      op_r  <= cmd_op;
      arg_r <= cmd_arg;
    end
  end

`ifdef JK_BANK_CTRL_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aborted <= 1'b0;
    end else if (stop_now) begin
      aborted <= 1'b1;
    end else if (state == ST_DONE) begin
      aborted <= 1'b0;
    end
  end
`endif

  // Ripple "all lower bits set" term for the up-counter.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      carry[i] = carry[i-1] & q_bus[i-1];
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    if (step_en) begin
      unique case (op_r)
        OP_CLEAR: begin
          j = '0;
          k = '1;
        end
        OP_LOAD: begin
          j = arg_r;
          k = ~arg_r;
        end
        OP_COUNT: begin
          j = carry;
          k = carry;
        end
        default: begin
          j = arg_r;
          k = arg_r;
        end
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .j    (j[g]),
      .k    (k[g]),
      .q    (q_bus[g]),
      .qbar (qbar_bus[g])
    );
  end

  assign q         = q_bus;
  assign qbar      = qbar_bus;
  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state == ST_EXEC) || (state == ST_DONE);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed self-checking bench for jk_bank_ctrl (WIDTH=4, CNT_W=8).
module tb_jk_bank_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic [7:0] cmd_len;
  logic [3:0] q;
  logic [3:0] qbar;
  logic       busy;
  logic       done;
`ifdef JK_BANK_CTRL_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  jk_bank_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cmd_len   (cmd_len),
`ifdef JK_BANK_CTRL_ABORT_EN
    .abort     (abort),
    .aborted   (aborted),
`endif
    .q         (q),
    .qbar      (qbar),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command for one edge (E0); returns #1 after E0.
  task automatic issue(input logic [1:0] op, input logic [3:0] arg, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_len   = len;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_arg   = 4'h0;
    cmd_len   = 8'd0;
`ifdef JK_BANK_CTRL_ABORT_EN
    abort     = 1'b0;
`endif
    step();
    step();
    chk("rst_q", q, 4'h0);
    chk("rst_qbar", qbar, 4'hF);
    chk("rst_ready_low", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    #1;
    chk("rel_ready", cmd_ready, 1'b1);

    // LOAD 1010
    issue(2'b01, 4'b1010, 8'd7);
    chk("ld_e0_ready", cmd_ready, 1'b0);
    chk("ld_e0_busy", busy, 1'b1);
    chk("ld_e0_q", q, 4'h0);
    chk("ld_e0_done", done, 1'b0);
    step();
    chk("ld_e1_q", q, 4'b1010);
    chk("ld_e1_qbar", qbar, 4'b0101);
    chk("ld_e1_done", done, 1'b1);
    chk("ld_e1_ready", cmd_ready, 1'b0);
    step();
    chk("ld_e2_done", done, 1'b0);
    chk("ld_e2_ready", cmd_ready, 1'b1);
    chk("ld_e2_busy", busy, 1'b0);

    // LOAD 1110 then COUNT len=3 (wraps through 1111 -> 0000)
    issue(2'b01, 4'b1110, 8'd0);
    step();
    chk("ld2_q", q, 4'b1110);
    step();
    issue(2'b10, 4'h0, 8'd3);
    chk("cnt_e0_q", q, 4'b1110);
    step();
    chk("cnt_e1_q", q, 4'b1111);
    chk("cnt_e1_done", done, 1'b0);
    step();
    chk("cnt_e2_q", q, 4'b0000);
    chk("cnt_e2_done", done, 1'b0);
    step();
    chk("cnt_e3_q", q, 4'b0001);
    chk("cnt_e3_done", done, 1'b1);
    step();
    chk("cnt_e4_ready", cmd_ready, 1'b1);
    chk("cnt_e4_done", done, 1'b0);

    // LOAD 0011, then TOGGLE 0101 len=2 with a CLEAR presented while busy
    issue(2'b01, 4'b0011, 8'd0);
    step();
    step();
    chk("ld3_q", q, 4'b0011);
    issue(2'b11, 4'b0101, 8'd2);
    step();
    chk("tg_e1_q", q, 4'b0110);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    step();
    cmd_valid = 1'b0;
    chk("tg_e2_q", q, 4'b0011);
    chk("tg_e2_done", done, 1'b1);
    step();
    chk("tg_e3_ready", cmd_ready, 1'b1);
    chk("tg_busy_ignored_q", q, 4'b0011);

    // COUNT len=0: straight to DONE, q untouched
    issue(2'b10, 4'h0, 8'd0);
    chk("z_e0_done", done, 1'b1);
    chk("z_e0_busy", busy, 1'b1);
    chk("z_e0_ready", cmd_ready, 1'b0);
    chk("z_e0_q", q, 4'b0011);
    step();
    chk("z_e1_done", done, 1'b0);
    chk("z_e1_ready", cmd_ready, 1'b1);
    chk("z_e1_q", q, 4'b0011);

    // CLEAR
    issue(2'b00, 4'hF, 8'd9);
    step();
    chk("clr_q", q, 4'h0);
    chk("clr_done", done, 1'b1);
    step();

    // COUNT len=10, reset asserted mid-command
    issue(2'b10, 4'h0, 8'd10);
    step();
    step();
    step();
    chk("cnt10_e3_q", q, 4'h3);
    rst = 1'b1;
    #1;
    chk("mid_rst_q", q, 4'h0);
    chk("mid_rst_qbar", qbar, 4'hF);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", cmd_ready, 1'b1);
    step();
    chk("mid_rel_q", q, 4'h0);
    chk("mid_rel_done", done, 1'b0);
    chk("mid_rel_busy", busy, 1'b0);

`ifdef JK_BANK_CTRL_ABORT_EN
    // COUNT len=10 from 0, abort during the third EXEC cycle
    issue(2'b10, 4'h0, 8'd10);
    step();
    step();
    chk("ab_e2_q", q, 4'h2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_q", q, 4'b0010);
    chk("ab_done", done, 1'b1);
    chk("ab_aborted", aborted, 1'b1);
    step();
    chk("ab_after_done", done, 1'b0);
    chk("ab_after_aborted", aborted, 1'b0);
    chk("ab_after_ready", cmd_ready, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_idle_ignored", aborted, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
